io_spi_slave_lite: RTL

SPI responder (slave) peripheral on the CPU IO bus, the counterpart of the existing SPI master, so the CPU can act as a target for an external SPI initiator. It synchronizes incoming SCK/CSN/MOSI into the system clock domain and shifts received bytes into an 8-entry RX FIFO. Bytes for MISO come from an 8-entry TX FIFO, or from a programmable fill byte when that FIFO is empty. Registers sit in the SPI IO window directly after the master's registers and use the same daisy-chained read-data mux.

---
 rtl/io_spi_slave_lite.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/io_spi_slave_lite.sv
// SPI responder on the CPU IO bus: synchronized SCK/CSN/MOSI, 8-entry TX/RX FIFOs, fill byte.
// Optional interrupt output enabled by defining SPI_SLAVE_IRQ_EN.
module io_spi_slave_lite (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_io_we,
  input  logic [15:2] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [15:2] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  input  logic        spi_sck,
  input  logic        spi_csn,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic        spi_slv_irq
`endif
);

  localparam logic [15:2] AdrMode = 14'h3C84;
  localparam logic [15:2] AdrTx   = 14'h3C85;
  localparam logic [15:2] AdrRx   = 14'h3C86;
  localparam logic [15:2] AdrStat = 14'h3C87;
  localparam logic [15:2] AdrFill = 14'h3C88;

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;
  state_e state_q, state_d;

  // [0] and [1] are the synchronizer stages, [2] is the edge-detect history
  logic [2:0] sck_sync, csn_sync, mosi_sync;
  logic       sck_rise, sck_fall, csn_rise, csn_fall, lead, trail;
  logic       sample_q, shift_q;

  logic       enable_q, cpha_q, cpol_q, msb_q, irq_en;
  logic [7:0] fill_q;
  logic       udr_q, ovr_q;

  logic [7:0] tx_mem [8];
  logic [2:0] tx_wp, tx_rp;
  logic [3:0] tx_cnt;
  logic       tx_empty, tx_full, tx_push, tx_pop, tx_flush;

  logic [7:0] rx_mem [8];
  logic [2:0] rx_wp, rx_rp;
  logic [3:0] rx_cnt;
  logic       rx_empty, rx_full, rx_push, rx_pop, rx_flush;

  logic [7:0] tx_sr, rx_sr, load_byte;
  logic [2:0] tx_idx, bit_cnt;
  logic       byte_done_q, load_now, miso_q, oe_q;
  logic       wr_mode, wr_stat, wr_fill, wr_rx;

  logic [31:0] rd_val, rd_q;
  logic        rd_sel_q, rd_hit;

  logic unused_wdata;
  assign unused_wdata = ^{dma_io_wdata[31:12], dma_io_wdata[9:8], mosi_sync[2]};

  function automatic logic bit_sel(input logic [7:0] b, input logic [2:0] i, input logic msb);
    return msb ? b[3'd7 - i] : b[i];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi_sck};
      csn_sync  <= {csn_sync[1:0], spi_csn};
      mosi_sync <= {mosi_sync[1:0], spi_mosi};
      sample_q  <= cpha_q ? trail : lead;
      shift_q   <= cpha_q ? lead : trail;
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign csn_rise = csn_sync[1] & ~csn_sync[2];
  assign csn_fall = ~csn_sync[1] & csn_sync[2];
  assign lead     = cpol_q ? sck_fall : sck_rise;
  assign trail    = cpol_q ? sck_rise : sck_fall;

  assign wr_mode  = dma_io_we & (dma_io_wadr == AdrMode);
  assign wr_stat  = dma_io_we & (dma_io_wadr == AdrStat);
  assign wr_fill  = dma_io_we & (dma_io_wadr == AdrFill);
  assign wr_rx    = dma_io_we & (dma_io_wadr == AdrRx);

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b0;
      cpha_q   <= 1'b0;
      cpol_q   <= 1'b0;
      msb_q    <= 1'b1;
      fill_q   <= 8'hFF;
    end else begin
      if (wr_mode) begin
        enable_q <= dma_io_wdata[0];
        cpha_q   <= dma_io_wdata[1];
        cpol_q   <= dma_io_wdata[2];
        msb_q    <= dma_io_wdata[3];
      end
      if (wr_fill) fill_q <= dma_io_wdata[7:0];
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  logic irq_en_q, irq_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_mode) irq_en_q <= dma_io_wdata[4];
      irq_q <= irq_en_q & (~rx_empty | ovr_q);
    end
  end
  assign irq_en      = irq_en_q;
  assign spi_slv_irq = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (csn_fall) state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: if (csn_rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!enable_q) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // A byte load happens on CSN fall and again right after every completed byte
  assign load_now  = enable_q & ((state_q == StLoad) |
                                 ((state_q == StShift) & byte_done_q & ~csn_rise));
  assign load_byte = tx_empty ? fill_q : tx_mem[tx_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      tx_sr       <= '0;
      tx_idx      <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      byte_done_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      if (!enable_q || state_q == StIdle) begin
        oe_q    <= 1'b0;
        miso_q  <= 1'b0;
        bit_cnt <= '0;
      end else if (state_q == StLoad) begin
        tx_sr   <= load_byte;
        oe_q    <= 1'b1;
        bit_cnt <= '0;
        if (!cpha_q) begin
          miso_q <= bit_sel(load_byte, 3'd0, msb_q);
          tx_idx <= 3'd1;
        end else begin
          tx_idx <= 3'd0;
        end
      end else if (csn_rise) begin
        bit_cnt <= '0;
      end else begin
        if (sample_q) begin
          rx_sr   <= msb_q ? {rx_sr[6:0], mosi_sync[1]} : {mosi_sync[1], rx_sr[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_done_q <= 1'b1;
        end
        if (byte_done_q) begin
          tx_sr  <= load_byte;
          tx_idx <= 3'd0;
        end else if (shift_q) begin
          miso_q <= bit_sel(tx_sr, tx_idx, msb_q);
          tx_idx <= tx_idx + 3'd1;
        end
      end
    end
  end

  assign tx_empty = (tx_cnt == 4'd0);
  assign tx_full  = (tx_cnt == 4'd8);
  assign tx_flush = wr_rx & dma_io_wdata[11];
  assign tx_push  = dma_io_we & (dma_io_wadr == AdrTx) & ~tx_full;
  assign tx_pop   = load_now & ~tx_empty;

  assign rx_empty = (rx_cnt == 4'd0);
  assign rx_full  = (rx_cnt == 4'd8);
  assign rx_flush = wr_rx & dma_io_wdata[10];
  assign rx_push  = byte_done_q & ~rx_full;
  assign rx_pop   = dma_io_radr_en & (dma_io_radr == AdrRx) & ~rx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= dma_io_wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_sr;
  end

  always_ff @(posedge clk) begin
    if (rst || tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 3'd1;
      if (tx_pop)  tx_rp <= tx_rp + 3'd1;
      tx_cnt <= tx_cnt + {3'd0, tx_push} - {3'd0, tx_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 3'd1;
      if (rx_pop)  rx_rp <= rx_rp + 3'd1;
      rx_cnt <= rx_cnt + {3'd0, rx_push} - {3'd0, rx_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      udr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (load_now && tx_empty)             udr_q <= 1'b1;
      else if (wr_stat && dma_io_wdata[0])  udr_q <= 1'b0;
      if (byte_done_q && rx_full)           ovr_q <= 1'b1;
      else if (wr_stat && dma_io_wdata[1])  ovr_q <= 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b1;
    case (dma_io_radr)
      AdrMode: rd_val = {27'd0, irq_en, msb_q, cpol_q, cpha_q, enable_q};
      AdrTx:   rd_val = {22'd0, tx_empty, tx_full, 8'd0};
      AdrRx:   rd_val = {22'd0, rx_empty, rx_full, rx_empty ? 8'd0 : rx_mem[rx_rp]};
      AdrStat: rd_val = {29'd0, ~csn_sync[1], ovr_q, udr_q};
      AdrFill: rd_val = {24'd0, fill_q};
      default: rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sel_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      rd_sel_q <= dma_io_radr_en & rd_hit;
      if (dma_io_radr_en) rd_q <= rd_val;
    end
  end

  assign dma_io_rdata = rd_sel_q ? rd_q : dma_io_rdata_in;
  assign spi_miso     = miso_q;
  assign spi_miso_oe  = oe_q;

endmodule
